// File: rtl/inst_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue_if
//   Bundles the ROM read port, the ID-stage handshake and the EX redirect
//   request of the instruction fetch front end.
//
//   Signals:
//     rom_ce        fetch -> ROM   read enable
//     rom_addr      fetch -> ROM   word-aligned byte address
//     rom_data      ROM -> fetch   read data, one cycle after rom_ce
//     id_valid      fetch -> ID    head instruction valid
//     id_pc         fetch -> ID    PC of head instruction
//     id_inst       fetch -> ID    head instruction word
//     id_ready      ID -> fetch    ID takes the head this cycle
//     branch_flag   EX -> fetch    redirect request
//     branch_target EX -> fetch    redirect address (low two bits ignored)
//
//   Modports:
//     master  the fetch queue itself
//     slave   the surrounding ROM / ID / EX environment
// ---------------------------------------------------------------------------
interface inst_fetch_queue_if;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;
  logic        branch_flag;
  logic [31:0] branch_target;

  modport master (
    output rom_ce, rom_addr, id_valid, id_pc, id_inst,
    input  rom_data, id_ready, branch_flag, branch_target
  );

  modport slave (
    input  rom_ce, rom_addr, id_valid, id_pc, id_inst,
    output rom_data, id_ready, branch_flag, branch_target
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
//   Instruction fetch front end sitting between the instruction ROM and the
//   ID stage. It generates the fetch PC, issues word reads to a ROM with a
//   one-cycle read latency, buffers returned instructions in a DEPTH-entry
//   prefetch FIFO and hands them to decode over a valid/ready handshake.
//   A branch redirect flushes the queue and drops the in-flight response.
//
//   Parameters:
//     DEPTH     queue entries (power of two, >= 2)
//     RESET_PC  first fetch address after reset
//
//   Ports:
//     clk   system clock, all state changes on the rising edge
//     rst   synchronous active-low reset
//     bus   inst_fetch_queue_if.master (ROM port, ID handshake, redirect)
//
//   Build option:
//     IFQ_BYPASS_EN  when defined, a live ROM response arriving while the
//                    queue is empty is shown to ID in the same cycle
//                    (1-cycle fetch-to-ID latency instead of 2).
// ---------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];

  logic [CW:0]   occupancy;
  logic          issue;
  logic          live_resp;
  logic          q_valid;
  logic          bypass_valid;
  logic          bypass_take;
  logic          enq_en;
  logic          deq_en;
  logic [31:0]   target_aligned;

  // Issue / enqueue / dequeue decisions, all derived from registered state
  // plus the current-cycle inputs. Occupancy counts the in-flight read so
  // that a returning word always has a free slot to land in. The only
  // response that can coexist with a branch is the one arriving in the
  // branch cycle itself, so gating it with branch_flag is what kills it.
  always_comb begin
    occupancy      = {1'b0, count} + {{CW{1'b0}}, inflight};
    issue          = rst && !bus.branch_flag && (occupancy < DEPTH_W);
    live_resp      = rst && inflight && !bus.branch_flag;
    q_valid        = (count != '0);
    target_aligned = bus.branch_target & 32'hFFFF_FFFC;
`ifdef IFQ_BYPASS_EN
    bypass_valid   = !q_valid && live_resp;
    bypass_take    = bypass_valid && bus.id_ready;
`else
    bypass_valid   = 1'b0;
    bypass_take    = 1'b0;
`endif
    enq_en         = live_resp && !bypass_take;
    deq_en         = q_valid && bus.id_ready;
  end

  // Outputs toward the ROM and ID. An empty queue presents PC 0 with a
  // zero instruction word so decode never sees a stale entry.
  always_comb begin
    bus.rom_ce   = issue;
    bus.rom_addr = fetch_pc;
    bus.id_valid = 1'b0;
    bus.id_pc    = 32'h0;
    bus.id_inst  = 32'h0;
    if (bypass_valid) begin
      bus.id_valid = 1'b1;
      bus.id_pc    = req_pc;
      bus.id_inst  = bus.rom_data;
    end else if (q_valid) begin
      bus.id_valid = 1'b1;
      bus.id_pc    = mem_pc[head];
      bus.id_inst  = mem_inst[head];
    end
  end

  // Control state: fetch PC, in-flight flag, queue pointers and count.
  // A branch wins over any enqueue or dequeue in the same cycle; a
  // handshake in that cycle is simply absorbed by the flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
      req_pc   <= 32'h0;
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (bus.branch_flag) begin
      fetch_pc <= target_aligned;
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
      end
      if (enq_en) begin
        tail <= tail + PW'(1);
      end
      if (deq_en) begin
        head <= head + PW'(1);
      end
      case ({enq_en, deq_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage. Not reset: contents are only visible while count says
  // the slot is occupied.
  always_ff @(posedge clk) begin
    if (enq_en) begin
      mem_pc[tail]   <= req_pc;
      mem_inst[tail] <= bus.rom_data;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_queue
//   Directed self-checking bench for inst_fetch_queue. A second instance with
//   RESET_PC = 32'hFFFFFFF8 runs alongside to exercise PC wrap-around.
//   Works with or without IFQ_BYPASS_EN (fetch-to-ID latency LAT).
// ---------------------------------------------------------------------------
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch_queue_if bus ();
  inst_fetch_queue_if bus2 ();

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  // Instruction word stored at a given address in the ROM model.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // One-cycle-latency ROM models for both instances.
  always @(posedge clk) begin
    if (bus.rom_ce)  bus.rom_data  <= rom_word(bus.rom_addr);
    if (bus2.rom_ce) bus2.rom_data <= rom_word(bus2.rom_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle, drive the inputs, let outputs settle.
  task automatic applyStimulus(input logic rst_v, input logic ready_v,
                               input logic br_v, input logic [31:0] tgt);
    @(negedge clk);
    rst               = rst_v;
    bus.id_ready      = ready_v;
    bus.branch_flag   = br_v;
    bus.branch_target = tgt;
    #1;
  endtask

  // The queue must never be written while full.
  always @(negedge clk) begin
    if (rst && dut.enq_en && (dut.count == 3'(DEPTH)))
      checkOutput("no_overflow", 32'd1, 32'd0);
  end

  initial begin
    int            wait_cycles;
    int            issues;
    logic [31:0]   last_addr;

    bus.rom_data       = 32'h0;
    bus.id_ready       = 1'b1;
    bus.branch_flag    = 1'b0;
    bus.branch_target  = 32'h0;
    bus2.rom_data      = 32'h0;
    bus2.id_ready      = 1'b1;
    bus2.branch_flag   = 1'b0;
    bus2.branch_target = 32'h0;

    // ---- reset held for 5 cycles ----
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("rst_rom_ce",   32'(bus.rom_ce),   32'd0);
    checkOutput("rst_rom_addr", bus.rom_addr,      32'h0);
    checkOutput("rst_id_valid", 32'(bus.id_valid), 32'd0);
    checkOutput("rst_id_pc",    bus.id_pc,         32'h0);
    checkOutput("rst_id_inst",  bus.id_inst,       32'h0);

    // ---- scenario 1 / 5: streaming fetch, plus wrap on second instance ----
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s1_rom_ce",    32'(bus.rom_ce), 32'd1);
    checkOutput("s1_rom_addr",  bus.rom_addr,    32'h0);
    checkOutput("s5_rom_addr",  bus2.rom_addr,   32'hFFFF_FFF8);
    wait_cycles = 0;
    while (!bus.id_valid && wait_cycles < 8) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      wait_cycles++;
    end
    checkOutput("s1_latency", 32'(wait_cycles), 32'(LAT));
    for (int k = 0; k < 4; k++) begin
      if (k > 0) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("s1_id_valid", 32'(bus.id_valid), 32'd1);
      checkOutput("s1_id_pc",    bus.id_pc,   32'(4 * k));
      checkOutput("s1_id_inst",  bus.id_inst, rom_word(32'(4 * k)));
      checkOutput("s1_stream_addr", bus.rom_addr, 32'(4 * (LAT + k)));
      checkOutput("s5_id_valid", 32'(bus2.id_valid), 32'd1);
      checkOutput("s5_id_pc",    bus2.id_pc, 32'hFFFF_FFF8 + 32'(4 * k));
    end

    // ---- scenario 4: one-cycle reset mid-stream ----
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("s4_ce_in_reset", 32'(bus.rom_ce), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s4_id_valid", 32'(bus.id_valid), 32'd0);
    checkOutput("s4_id_pc",    bus.id_pc,         32'h0);
    checkOutput("s4_id_inst",  bus.id_inst,       32'h0);
    checkOutput("s4_rom_ce",   32'(bus.rom_ce),   32'd1);
    checkOutput("s4_rom_addr", bus.rom_addr,      32'h0);
    repeat (LAT) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s4_restart_valid", 32'(bus.id_valid), 32'd1);
    checkOutput("s4_restart_pc",    bus.id_pc,         32'h0);
    checkOutput("s4_restart_inst",  bus.id_inst,       rom_word(32'h0));

    // ---- scenario 2: ID stalled, queue fills, then drains ----
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    issues    = 0;
    last_addr = 32'h0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      if (bus.rom_ce) begin
        issues++;
        last_addr = bus.rom_addr;
      end
    end
    checkOutput("s2_issue_count", 32'(issues), 32'd4);
    checkOutput("s2_last_addr",   last_addr,   32'hC);
    checkOutput("s2_full_ce",     32'(bus.rom_ce),   32'd0);
    checkOutput("s2_full_valid",  32'(bus.id_valid), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s2_drain_pc0", bus.id_pc,       32'h0);
    checkOutput("s2_drain_ce0", 32'(bus.rom_ce), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s2_drain_pc1",    bus.id_pc,       32'h4);
    checkOutput("s2_resume_ce",    32'(bus.rom_ce), 32'd1);
    checkOutput("s2_resume_addr",  bus.rom_addr,    32'h10);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s2_drain_pc2", bus.id_pc, 32'h8);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s2_drain_pc3",   bus.id_pc,   32'hC);
    checkOutput("s2_drain_inst3", bus.id_inst, rom_word(32'hC));
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s2_next_pc",   bus.id_pc,   32'h10);
    checkOutput("s2_next_inst", bus.id_inst, rom_word(32'h10));

    // ---- scenario 3: branch with 2 queued entries and one in flight ----
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h103);
    checkOutput("s3_br_ce",    32'(bus.rom_ce),   32'd0);
    checkOutput("s3_br_valid", 32'(bus.id_valid), 32'd1);
    checkOutput("s3_br_pc",    bus.id_pc,         32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s3_flush_valid", 32'(bus.id_valid), 32'd0);
    checkOutput("s3_target_ce",   32'(bus.rom_ce),   32'd1);
    checkOutput("s3_target_addr", bus.rom_addr,      32'h100);
    repeat (LAT) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s3_target_valid", 32'(bus.id_valid), 32'd1);
    checkOutput("s3_target_pc",    bus.id_pc,         32'h100);
    checkOutput("s3_target_inst",  bus.id_inst,       rom_word(32'h100));
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s3_after_pc", bus.id_pc, 32'h104);

    // ---- scenario 6: branch on the cycle a response arrives, queue empty ----
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s6_issue_ce", 32'(bus.rom_ce), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h202);
    checkOutput("s6_kill_valid", 32'(bus.id_valid), 32'd0);
    checkOutput("s6_kill_ce",    32'(bus.rom_ce),   32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s6_post_valid", 32'(bus.id_valid), 32'd0);
    checkOutput("s6_post_addr",  bus.rom_addr,      32'h200);
    repeat (LAT) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s6_target_pc",   bus.id_pc,   32'h200);
    checkOutput("s6_target_inst", bus.id_inst, rom_word(32'h200));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
